// File: rtl/encoder_pkg.sv
// rtl/encoder_pkg.sv - shared state type and width helpers for the encoder arbiter
package encoder_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    RUN,
    REPORT,
    FAULT
  } arb_state_t;

  localparam int DEF_NUM_REQ    = 4;
  localparam int DEF_ADDR_WIDTH = 4;
  localparam int DEF_TIMEOUT    = 1024;

  function automatic int timer_width(input int timeout);
    return $clog2(timeout);
  endfunction

  function automatic int count_width(input int addr_width);
    return addr_width + 1;
  endfunction

  function automatic int idx_width(input int num_req);
    return (num_req > 1) ? $clog2(num_req) : 1;
  endfunction

endpackage

// File: rtl/encoder_arbiter_rr_pick.sv
// rtl/encoder_arbiter_rr_pick.sv - combinational round-robin pick starting at ptr
module rr_pick
  import encoder_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  localparam int IW = idx_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IW-1:0]      ptr,
  output logic [NUM_REQ-1:0] onehot,
  output logic [IW-1:0]      idx,
  output logic               valid
);

  logic [IW-1:0] cand;

  always_comb begin
    onehot = '0;
    idx    = '0;
    valid  = 1'b0;
    cand   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = IW'((int'(ptr) + k) % NUM_REQ);
      if (!valid && req[cand]) begin
        valid        = 1'b1;
        idx          = cand;
        onehot[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/encoder_arbiter.sv
// rtl/encoder_arbiter.sv - round-robin owner of a shared encoder with job watchdog
module encoder_arbiter
  import encoder_pkg::*;
#(
  parameter int NUM_REQ    = DEF_NUM_REQ,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int TIMEOUT    = DEF_TIMEOUT
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] base_addr,
  output logic [NUM_REQ-1:0]            grant,
  output logic [NUM_REQ-1:0]            ack,
  output logic [NUM_REQ-1:0]            err,
  output logic [ADDR_WIDTH:0]           res_count,
  output logic                          busy,
  output logic                          enc_cs,
  output logic [ADDR_WIDTH-1:0]         enc_base,
  output logic                          enc_clr,
  input  logic                          enc_done,
  input  logic [ADDR_WIDTH:0]           enc_count
);

  localparam int IW = idx_width(NUM_REQ);
  localparam int TW = timer_width(TIMEOUT);
  localparam int CW = count_width(ADDR_WIDTH);

  arb_state_t          state_q, state_d;
  logic [IW-1:0]       ptr_q, ptr_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic [TW-1:0]       timer_q, timer_d;
  logic [ADDR_WIDTH-1:0] base_q, base_d;
  logic [CW-1:0]       res_count_q, res_count_d;

  logic [NUM_REQ-1:0]  pick_onehot;
  logic [IW-1:0]       pick_idx;
  logic                pick_valid;
  logic [NUM_REQ-1:0]  idx_onehot;
  logic [IW-1:0]       idx_next;

  rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .req    (req),
    .ptr    (ptr_q),
    .onehot (pick_onehot),
    .idx    (pick_idx),
    .valid  (pick_valid)
  );

  assign idx_onehot = NUM_REQ'(1) << idx_q;
  assign idx_next   = (idx_q == IW'(NUM_REQ - 1)) ? '0 : idx_q + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      idx_q       <= '0;
      timer_q     <= '0;
      base_q      <= '0;
      res_count_q <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      idx_q       <= idx_d;
      timer_q     <= timer_d;
      base_q      <= base_d;
      res_count_q <= res_count_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    idx_d       = idx_q;
    timer_d     = timer_q;
    base_d      = base_q;
    res_count_d = res_count_q;
    case (state_q)
      IDLE: begin
        if (pick_valid) begin
          idx_d = pick_idx;
          for (int i = 0; i < NUM_REQ; i++) begin
            if (pick_onehot[i]) base_d = base_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
          end
          state_d = START;
        end
      end
      // enc_done is deliberately not looked at here: it may still be up from the previous job
      START: begin
        timer_d = '0;
        state_d = RUN;
      end
      RUN: begin
        if (enc_done) begin
          res_count_d = enc_count;
          state_d     = REPORT;
        end else if (timer_q == TW'(TIMEOUT - 1)) begin
          state_d = FAULT;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      REPORT, FAULT: begin
        ptr_d   = idx_next;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    grant    = '0;
    ack      = '0;
    err      = '0;
    busy     = (state_q != IDLE);
    enc_cs   = 1'b0;
    enc_base = '0;
    enc_clr  = 1'b0;
    case (state_q)
      START, RUN: begin
        grant    = idx_onehot;
        enc_cs   = 1'b1;
        enc_base = base_q;
      end
      REPORT: ack = idx_onehot;
      FAULT: begin
        err     = idx_onehot;
        enc_clr = 1'b1;
      end
      default: ;
    endcase
  end

  assign res_count = res_count_q;

endmodule

// File: tb/tb_encoder_arbiter.sv
// tb/tb_encoder_arbiter.sv - randomized scoreboard bench for encoder_arbiter
module tb_encoder_arbiter;

  localparam int NR = 4;
  localparam int AW = 4;
  localparam int TO = 16;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [NR-1:0]   req = '0;
  logic [NR*AW-1:0] base_addr = '0;
  logic [NR-1:0]   grant, ack, err;
  logic [AW:0]     res_count;
  logic            busy, enc_cs, enc_clr;
  logic [AW-1:0]   enc_base;
  logic            enc_done = 1'b0;
  logic [AW:0]     enc_count = '0;

  always #5 clk = ~clk;

  encoder_arbiter #(.NUM_REQ(NR), .ADDR_WIDTH(AW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .req(req), .base_addr(base_addr),
    .grant(grant), .ack(ack), .err(err), .res_count(res_count),
    .busy(busy), .enc_cs(enc_cs), .enc_base(enc_base), .enc_clr(enc_clr),
    .enc_done(enc_done), .enc_count(enc_count)
  );

  typedef struct {
    int base;
    int delay;
    int count;
    bit hang;
    bit stale;
  } plan_t;

  typedef struct {
    int idx;
    int base;
    bit is_err;
    int count;
    int lat;
  } exp_t;

  plan_t plans[NR][4];
  int    cnt[NR];
  int    pos[NR];
  exp_t  exp_q[$];
  int    mptr = 0;
  int    last_count = 0;
  bit    sb_off = 1'b0;
  int    total = 0;
  int    bad = 0;

  task automatic chk(input string name, input longint act, input longint want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, want, $time);
    end
  endtask

  function automatic bit onehot0(input logic [NR-1:0] v);
    return (v & (v - 1'b1)) == '0;
  endfunction

  function automatic plan_t rand_plan(input bit allow_hang);
    plan_t p;
    p.base  = int'($urandom_range(0, 15));
    p.delay = int'($urandom_range(1, TO));
    p.count = int'($urandom_range(0, 31));
    p.hang  = allow_hang && ($urandom_range(0, 7) == 0);
    p.stale = 1'b0;
    return p;
  endfunction

  function automatic plan_t mk_plan(input int b, input int d, input int c, input bit h, input bit s);
    plan_t p;
    p.base = b; p.delay = d; p.count = c; p.hang = h; p.stale = s;
    return p;
  endfunction

  task automatic clear_plans();
    for (int i = 0; i < NR; i++) cnt[i] = 0;
  endtask

  // Reference: pending requesters served round-robin from the last winner + 1.
  task automatic issue_batch(input bit push);
    int    mpos[NR];
    int    w;
    int    jj;
    plan_t p;
    exp_t  e;
    for (int i = 0; i < NR; i++) mpos[i] = 0;
    if (push) begin
      for (int n = 0; n < 64; n++) begin
        w = -1;
        for (int k = 0; k < NR; k++) begin
          jj = (mptr + k) % NR;
          if (w < 0 && mpos[jj] < cnt[jj]) w = jj;
        end
        if (w < 0) break;
        p = plans[w][mpos[w]];
        if (!p.hang) last_count = p.count;
        e.idx    = w;
        e.base   = p.base;
        e.is_err = p.hang;
        e.count  = last_count;
        e.lat    = p.hang ? TO + 1 : p.delay + 1;
        exp_q.push_back(e);
        mpos[w]++;
        mptr = (w + 1) % NR;
      end
    end
    for (int i = 0; i < NR; i++) begin
      pos[i] = 0;
      req[i] = (cnt[i] > 0);
      if (cnt[i] > 0) base_addr[i*AW +: AW] = AW'(plans[i][0].base);
    end
  endtask

  task automatic wait_done();
    bit ok;
    ok = 1'b0;
    for (int c = 0; c < 2000; c++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !busy) begin
        ok = 1'b1;
        break;
      end
    end
    chk("batch_complete", ok, 1);
    if (!ok) exp_q.delete();
  endtask

  // Encoder model and requester side: responds to cs, drops or re-arms req on ack/err.
  initial begin
    bit    active;
    int    cnt_dn;
    int    j;
    plan_t cur;
    active = 1'b0;
    cnt_dn = 0;
    cur    = mk_plan(0, 1, 0, 1'b1, 1'b0);
    forever begin
      @(negedge clk);
      enc_done = 1'b0;
      if (rst || !enc_cs) begin
        active = 1'b0;
      end else if (!active) begin
        active = 1'b1;
        j = 0;
        for (int i = 0; i < NR; i++) if (grant[i]) j = i;
        if (pos[j] < cnt[j]) cur = plans[j][pos[j]];
        else cur = mk_plan(0, 1, 0, 1'b1, 1'b0);
        cnt_dn = cur.delay;
        if (cur.stale) begin
          enc_done  = 1'b1;
          enc_count = (AW+1)'(~cur.count);
        end
      end else if (!cur.hang && cnt_dn > 0) begin
        cnt_dn--;
        if (cnt_dn == 0) begin
          enc_done  = 1'b1;
          enc_count = (AW+1)'(cur.count);
        end
      end
      for (int i = 0; i < NR; i++) begin
        if ((ack[i] || err[i]) && pos[i] < cnt[i]) begin
          pos[i]++;
          if (pos[i] < cnt[i]) base_addr[i*AW +: AW] = AW'(plans[i][pos[i]].base);
          else req[i] = 1'b0;
        end
      end
    end
  end

  // Monitor: checks invariants every cycle and pops the scoreboard on each ack/err.
  initial begin
    bit            in_job;
    bit            chk_idle;
    int            t;
    exp_t          e;
    logic [NR-1:0] ea, ee;
    in_job = 1'b0;
    chk_idle = 1'b0;
    t = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        in_job = 1'b0;
        chk_idle = 1'b0;
      end else begin
        chk("invariants", {onehot0(grant), onehot0(ack), onehot0(err),
                           !((|ack) && (|err)), enc_clr == (|err)}, 5'b11111);
        if (chk_idle) begin
          chk("turnaround_idle", {busy, enc_cs}, 0);
          chk_idle = 1'b0;
        end
        if (in_job) t++;
        if (!sb_off && !in_job && grant != '0) begin
          in_job = 1'b1;
          t = 0;
          if (exp_q.size() == 0) chk("spurious_grant", grant, 0);
          else begin
            ea = NR'(1) << exp_q[0].idx;
            chk("grant_start", {grant, enc_base, enc_cs}, {ea, AW'(exp_q[0].base), 1'b1});
          end
        end
        if (!sb_off && (ack != '0 || err != '0)) begin
          if (exp_q.size() == 0) chk("spurious_done", {ack, err}, 0);
          else begin
            e  = exp_q.pop_front();
            ea = e.is_err ? '0 : NR'(1) << e.idx;
            ee = e.is_err ? NR'(1) << e.idx : '0;
            chk("done_vec", {ack, err, enc_clr}, {ea, ee, e.is_err});
            chk("res_count", res_count, e.count);
            chk("done_latency", t, e.lat);
            chk("done_cs_off", {grant, enc_cs}, 0);
          end
          in_job = 1'b0;
          chk_idle = 1'b1;
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("reset_outputs", {grant, ack, err, busy, enc_cs, enc_base, enc_clr, res_count}, 0);
    rst = 1'b0;

    // every requester pending from reset, requester 0 re-arms after its ack
    clear_plans();
    for (int i = 0; i < NR; i++) begin
      cnt[i] = 1;
      plans[i][0] = rand_plan(1'b0);
    end
    cnt[0] = 2;
    plans[0][1] = rand_plan(1'b0);
    issue_batch(1'b1);
    wait_done();

    // single job on requester 2
    clear_plans();
    cnt[2] = 1;
    plans[2][0] = mk_plan(5, 10, 3, 1'b0, 1'b0);
    issue_batch(1'b1);
    @(negedge clk);
    chk("single_grant", {grant, enc_base}, {4'b0100, 4'h5});
    wait_done();
    chk("single_res_count", res_count, 3);

    // 3 and 0 pending right after serving 2
    clear_plans();
    cnt[0] = 1; plans[0][0] = rand_plan(1'b0);
    cnt[3] = 1; plans[3][0] = rand_plan(1'b0);
    issue_batch(1'b1);
    wait_done();

    // hung job on 1 times out, then 2 is served
    clear_plans();
    cnt[1] = 1; plans[1][0] = mk_plan(9, 1, 0, 1'b1, 1'b0);
    cnt[2] = 1; plans[2][0] = mk_plan(6, 4, 17, 1'b0, 1'b0);
    issue_batch(1'b1);
    wait_done();

    // done on the last allowed RUN cycle wins over timeout
    clear_plans();
    cnt[3] = 1; plans[3][0] = mk_plan(2, TO, 9, 1'b0, 1'b0);
    issue_batch(1'b1);
    wait_done();

    for (int b = 0; b < 6; b++) begin
      clear_plans();
      for (int i = 0; i < NR; i++) begin
        cnt[i] = int'($urandom_range(0, 2));
        for (int k = 0; k < cnt[i]; k++) plans[i][k] = rand_plan(1'b1);
      end
      if (cnt[0] == 0 && cnt[1] == 0 && cnt[2] == 0 && cnt[3] == 0) begin
        cnt[b % NR] = 1;
        plans[b % NR][0] = rand_plan(1'b1);
      end
      issue_batch(1'b1);
      wait_done();
    end

    // leave ptr at 3 with a nonzero result, then reset in the middle of a hung job
    clear_plans();
    cnt[2] = 1; plans[2][0] = mk_plan(11, 3, 21, 1'b0, 1'b0);
    issue_batch(1'b1);
    wait_done();
    clear_plans();
    cnt[0] = 1; plans[0][0] = mk_plan(7, 1, 0, 1'b1, 1'b0);
    sb_off = 1'b1;
    issue_batch(1'b0);
    repeat (6) @(negedge clk);
    chk("hung_running", {busy, enc_cs}, 2'b11);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_mid_run", {grant, ack, err, busy, enc_cs, enc_base, enc_clr, res_count}, 0);
    rst = 1'b0;
    req = '0;
    clear_plans();
    mptr = 0;
    last_count = 0;
    sb_off = 1'b0;

    // ptr restarts at 0 so 1 wins over 3; its START sees a stale done
    cnt[1] = 1; plans[1][0] = mk_plan(12, 5, 13, 1'b0, 1'b1);
    cnt[3] = 1; plans[3][0] = mk_plan(4, 2, 30, 1'b0, 1'b0);
    issue_batch(1'b1);
    wait_done();

    for (int b = 0; b < 4; b++) begin
      clear_plans();
      for (int i = 0; i < NR; i++) begin
        cnt[i] = int'($urandom_range(0, 3));
        for (int k = 0; k < cnt[i]; k++) plans[i][k] = rand_plan(1'b1);
      end
      if (cnt[0] == 0 && cnt[1] == 0 && cnt[2] == 0 && cnt[3] == 0) begin
        cnt[b % NR] = 1;
        plans[b % NR][0] = rand_plan(1'b0);
      end
      issue_batch(1'b1);
      wait_done();
    end

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
